disp_scan_ctrl: RTL and testbench
=================================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, gives clk cycles per digit slot (1 kHz per digit at 100 MHz); legal values are 2 and above.
REQ-002 Parameter BLANK_LZ, default 1, enables leading-zero blanking when set to 1.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port bin, input, 14 bits: unsigned binary value to display.
REQ-006 Port load, input, 1 bit: request to convert and display bin.
REQ-007 Port busy, output, 1 bit: conversion in progress.
REQ-008 Port ovf, output, 1 bit: the last accepted value exceeded 9999.
REQ-009 Port an, output, 4 bits: digit enables, active-low; an[0] is the units digit.
REQ-010 Port bcd, output, 4 bits: code for the enabled digit, 0-9, or 4'hF for blank; this port feeds the seven-segment decoder directly.

Function
REQ-011 An edge with load=1 and busy=0 SHALL accept the value: capture min(bin, 9999), set ovf=(bin>9999) and set busy=1.
REQ-012 load while busy=1 SHALL be ignored, with no queueing and no effect on the capture or on ovf.
REQ-013 Conversion SHALL be sequential shift-add-3 (double dabble) performing exactly 14 shift steps, one per clk edge, after the accept edge.
REQ-014 On the 14th shift edge, all four display digits SHALL update together in one edge and busy SHALL return to 0; busy is high for exactly 14 cycles.
REQ-015 Displayed digits SHALL hold their previous value throughout conversion, so no partial result is ever visible on bcd.
REQ-016 A new load is accepted on the first edge at which busy=0, including the cycle immediately after busy falls.
REQ-017 Prescaler SHALL count 0..REFRESH_DIV-1 and then wrap to 0; it free-runs and is independent of load and busy.
REQ-018 On each prescaler wrap, digit index idx SHALL advance 0->1->2->3->0.
REQ-019 an SHALL equal ~(4'b0001 << idx); exactly one bit of an is low at all times outside reset.
REQ-020 bcd SHALL equal digit[idx], where digit 0 is units and digit 3 is thousands.
REQ-021 With BLANK_LZ=1, digit k (k=3..1) SHALL show 4'hF when digit k and every higher digit are 0; digit 0 is never blanked.
REQ-022 With BLANK_LZ=0, blanking SHALL not occur.
REQ-023 an and bcd SHALL be driven from registered state only, with no combinational path from bin or load.
REQ-024 Each BCD digit SHALL stay within 0-9 after every commit.

Reset
REQ-025 While rst=1, the block SHALL hold: prescaler=0, idx=0, all digits=0, busy=0, ovf=0, an=4'b1110, bcd=4'h0.
REQ-026 rst asserted mid-conversion SHALL abort that conversion with no digit commit, leaving digits=0 and busy=0.
REQ-027 After rst deasserts, the first load edge is accepted normally and the prescaler restarts from 0.

Verification (bench runs with REFRESH_DIV=4)
REQ-028 Load 1234 -> busy high for 14 cycles; then over successive slots an/bcd = 1110/4, 1101/3, 1011/2, 0111/1, with each slot lasting 4 cycles.
REQ-029 Load 7, BLANK_LZ=1 -> an 1110 shows bcd=7, and an 1101, 1011 and 0111 show bcd=F; load 0 -> units shows 0 and the other three digits show F.
REQ-030 Load 12000 -> ovf=1 and the display shows 9999; then load 5 -> ovf=0.
REQ-031 Load 4321, then pulse load with 1111 at busy cycle 5 -> the second load is ignored, the display shows 4321, and busy stays high for exactly 14 cycles.
REQ-032 Load 9876 committed, then load 1000 with rst pulsed at busy cycle 7 -> digits=0, busy=0, an=1110, bcd=0 during reset.
REQ-033 Back-to-back: load 55, then load 66 on the first edge after busy falls -> both are accepted and 66 is displayed 14 cycles after the second acceptance.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with a sequential
// binary-to-BCD (double dabble) converter and optional leading-zero blanking.
module disp_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] bin,
    input  logic        load,
    output logic        busy,
    output logic        ovf,
    output logic [3:0]  an,
    output logic [3:0]  bcd
);
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t        state, state_nxt;
    logic          accept, commit;
    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [13:0]   sr;
    logic [15:0]   acc, acc_adj, acc_nxt;
    logic [3:0]    step;
    logic [15:0]   digits;
    logic [3:0]    blank;
    logic [3:0]    digit_sel;

    function automatic logic [13:0] sat_9999(input logic [13:0] v);
        return (v > 14'd9999) ? 14'd9999 : v;
    endfunction

    function automatic logic [15:0] add3(input logic [15:0] a);
        logic [15:0] r;
        r = a;
        for (int k = 0; k < 4; k++)
            if (r[k*4 +: 4] >= 4'd5) r[k*4 +: 4] = r[k*4 +: 4] + 4'd3;
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: if (load) begin
                accept    = 1'b1;
                state_nxt = CONV;
            end
            CONV: if (step == 4'd13) begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state == CONV);
    assign acc_adj = add3(acc);
    assign acc_nxt = {acc_adj[14:0], sr[13]};

    // Conversion works on a private shift register; digits only change on commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr     <= '0;
            acc    <= '0;
            step   <= '0;
            ovf    <= 1'b0;
            digits <= '0;
        end else if (accept) begin
            sr   <= sat_9999(bin);
            acc  <= '0;
            step <= '0;
            ovf  <= (bin > 14'd9999);
        end else if (busy) begin
            sr   <= {sr[12:0], 1'b0};
            acc  <= acc_nxt;
            step <= step + 4'd1;
            if (commit) digits <= acc_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_comb begin
        blank[0] = 1'b0;
        blank[3] = (digits[15:12] == 4'd0);
        blank[2] = blank[3] && (digits[11:8] == 4'd0);
        blank[1] = blank[2] && (digits[7:4] == 4'd0);
    end

    assign digit_sel = digits[{idx, 2'b00} +: 4];
    assign an        = ~(4'b0001 << idx);
    assign bcd       = ((BLANK_LZ == 1) && blank[idx]) ? 4'hF : digit_sel;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: table of load values with expected
// digit/ovf results, scoreboard of expected scan slots, plus corner sequences.
module tb_disp_scan_ctrl;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [13:0] bin = '0;
    logic        busy, ovf;
    logic [3:0]  an, bcd;

    disp_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .bin(bin), .load(load),
        .busy(busy), .ovf(ovf), .an(an), .bcd(bcd)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] bcd;
    } slot_t;
    slot_t sb[$];

    typedef struct packed {
        logic [13:0] value;
        logic        exp_ovf;
        logic [15:0] exp_disp;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] d);
        slot_t s;
        for (int k = 0; k < 4; k++) begin
            s.an  = ~(4'b0001 << k);
            s.bcd = d[k*4 +: 4];
            sb.push_back(s);
        end
    endtask

    // Called at a negedge with busy low; returns at the negedge where busy is low again.
    task automatic do_load(input logic [13:0] v, input logic exp_ovf,
                           input int inj_cyc, input logic [13:0] inj_v);
        int cnt;
        bin  = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("ovf_on_accept", ovf, exp_ovf);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            if (cnt == inj_cyc) begin
                bin  = inj_v;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        chk("busy_cycles", cnt, 14);
        chk("ovf_hold", ovf, exp_ovf);
    endtask

    task automatic check_display();
        int    cnt;
        int    d;
        slot_t e;
        logic [3:0] s;
        cnt = 0;
        while (an == 4'b1110 && cnt < 60) begin @(negedge clk); cnt++; end
        while (an != 4'b1110 && cnt < 60) begin @(negedge clk); cnt++; end
        if (cnt >= 60) begin
            checks++;
            failures++;
            $display("FAIL scan_align timeout actual=%0d required<60", cnt);
        end
        for (int k = 0; k < 4; k++) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty actual=0 required=1");
                return;
            end
            e = sb.pop_front();
            chk("slot_an", an, e.an);
            chk("slot_bcd", bcd, e.bcd);
            s = an;
            d = 0;
            while (an == s && d < 40) begin @(negedge clk); d++; end
            chk("slot_len", d, RD);
        end
    endtask

    initial begin
        vecs[0] = '{value: 14'd1234,  exp_ovf: 1'b0, exp_disp: 16'h1234};
        vecs[1] = '{value: 14'd7,     exp_ovf: 1'b0, exp_disp: 16'hFFF7};
        vecs[2] = '{value: 14'd0,     exp_ovf: 1'b0, exp_disp: 16'hFFF0};
        vecs[3] = '{value: 14'd12000, exp_ovf: 1'b1, exp_disp: 16'h9999};
        vecs[4] = '{value: 14'd5,     exp_ovf: 1'b0, exp_disp: 16'hFFF5};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_an", an, 4'b1110);
        chk("rst_bcd", bcd, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        push_exp(16'hFFF0);
        check_display();

        foreach (vecs[i]) begin
            do_load(vecs[i].value, vecs[i].exp_ovf, 0, 14'd0);
            push_exp(vecs[i].exp_disp);
            check_display();
        end

        // Load during conversion is ignored
        do_load(14'd4321, 1'b0, 5, 14'd1111);
        push_exp(16'h4321);
        check_display();

        // Back-to-back acceptance
        do_load(14'd55, 1'b0, 0, 14'd0);
        do_load(14'd66, 1'b0, 0, 14'd0);
        push_exp(16'hFF66);
        check_display();

        // Reset aborts an in-flight conversion
        do_load(14'd9876, 1'b0, 0, 14'd0);
        push_exp(16'h9876);
        check_display();
        bin  = 14'd1000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async_busy", busy, 1'b0);
        @(negedge clk);
        chk("rst_mid_an", an, 4'b1110);
        chk("rst_mid_bcd", bcd, 4'h0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_ovf", ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        push_exp(16'hFFF0);
        check_display();

        // First load after reset is accepted normally
        do_load(14'd42, 1'b0, 0, 14'd0);
        push_exp(16'hFF42);
        check_display();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=expired required=finish");
        $fatal(1, "timeout");
    end
endmodule
